// File: rtl/ans_count_if.sv
// Count-stream link between ans_count_sender and the loader side.
// Four-phase handshake: receiver idles with out_rdy=1; sender raises out_vld with
// out_data stable, receiver captures and drops out_rdy, sender drops out_vld,
// receiver raises out_rdy again to complete the transfer.
interface ans_count_if #(
    parameter int CNT_WIDTH = 12
);
    logic [CNT_WIDTH-1:0] out_data;
    logic                 out_vld;
    logic                 out_rdy;

    modport master (output out_data, output out_vld, input out_rdy);
    modport slave  (input out_data, input out_vld, output out_rdy);
endinterface

// File: rtl/ans_count_sender.sv
// Streams a SYM_COUNT-entry frequency table, entry 0 first, over the four-phase
// count link and keeps a running sum of the counts sent in the current frame.
module ans_count_sender #(
    parameter int SYM_WIDTH = 8,
    parameter int CNT_WIDTH = 12,
    parameter int SYM_COUNT = 2**SYM_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [SYM_WIDTH-1:0]           tbl_addr,
    input  logic [CNT_WIDTH-1:0]           tbl_data,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0] sum_total,
    output logic [2:0]                     state_dbg,
    ans_count_if.master                    cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        FETCH    = 3'd2,
        SEND     = 3'd3,
        RELEASE  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SYM_WIDTH-1:0] idx;

    assign tbl_addr  = idx;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = WAIT_RDY;
            WAIT_RDY: if (cnt.out_rdy) state_nxt = FETCH;
            FETCH:    state_nxt = SEND;
            SEND:     if (!cnt.out_rdy) state_nxt = RELEASE;
            RELEASE: begin
                if (cnt.out_rdy) state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Handshake strobes decode straight from the state register.
    always_comb begin
        cnt.out_vld = 1'b0;
        done        = 1'b0;
        case (state)
            SEND:    cnt.out_vld = 1'b1;
            DONE:    done        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            cnt.out_data <= '0;
            sum_total    <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        sum_total <= '0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    cnt.out_data <= tbl_data;
                    sum_total    <= sum_total + {{SYM_WIDTH{1'b0}}, tbl_data};
                end
                RELEASE: begin
                    if (cnt.out_rdy && (idx != LAST_IDX)) idx <= idx + 1'b1;
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ans_count_sender.sv
// Directed bench for ans_count_sender: 4-entry frames against a model four-phase
// receiver, plus a narrow-count instance for the all-max-count frame.
module tb_ans_count_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, start2;
    logic        busy, done, busy2, done2;
    logic [1:0]  addr, addr2;
    logic [11:0] tdata;
    logic [3:0]  tdata2;
    logic [13:0] sum;
    logic [5:0]  sum2;
    logic [2:0]  st, st2;
    logic        stall;

    logic [11:0] tbl [0:3];
    logic [11:0] cap [0:63];
    logic [3:0]  cap2 [0:63];
    int          cap_n  = 0;
    int          cap2_n = 0;
    logic [11:0] exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    ans_count_if #(.CNT_WIDTH(12)) bus ();
    ans_count_if #(.CNT_WIDTH(4))  bus2 ();

    assign tdata  = tbl[addr];
    assign tdata2 = 4'd15;

    ans_count_sender #(.SYM_WIDTH(2), .CNT_WIDTH(12), .SYM_COUNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .tbl_addr(addr), .tbl_data(tdata), .sum_total(sum), .state_dbg(st), .cnt(bus)
    );

    ans_count_sender #(.SYM_WIDTH(2), .CNT_WIDTH(4), .SYM_COUNT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .tbl_addr(addr2), .tbl_data(tdata2), .sum_total(sum2), .state_dbg(st2), .cnt(bus2)
    );

    // Model receiver: captures on vld while idle-ready, re-arms once vld drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_rdy <= 1'b1;
        end else if (bus.out_rdy && bus.out_vld && !stall) begin
            bus.out_rdy <= 1'b0;
            cap[cap_n[5:0]] <= bus.out_data;
            cap_n <= cap_n + 1;
        end else if (!bus.out_rdy && !bus.out_vld) begin
            bus.out_rdy <= 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus2.out_rdy <= 1'b1;
        end else if (bus2.out_rdy && bus2.out_vld) begin
            bus2.out_rdy <= 1'b0;
            cap2[cap2_n[5:0]] <= bus2.out_data;
            cap2_n <= cap2_n + 1;
        end else if (!bus2.out_rdy && !bus2.out_vld) begin
            bus2.out_rdy <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Raise start, then sample every cycle until done (or the budget runs out).
    task automatic run_frame(input bit pulse, output int bcyc, output int vcyc, output int dcnt);
        bcyc = 0; vcyc = 0; dcnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pulse && i == 0) start = 1'b0;
            if (done) begin
                dcnt++;
                break;
            end
            if (busy) bcyc++;
            if (bus.out_vld) vcyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int base);
        int extra_done;
        exp_q = '{12'd5, 12'd0, 12'd7, 12'd4};
        check({tag, "_sum"}, 32'(sum), 32'd16);
        check({tag, "_xfers"}, 32'(cap_n - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            logic [5:0] ci;
            ci = 6'(base + k);
            check($sformatf("%s_entry%0d", tag, k), 32'(cap[ci]), 32'(exp_q.pop_front()));
        end
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check({tag, "_single_done"}, 32'(extra_done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  bcyc, vcyc, dcnt, base, base2, found;
        int  done_at[$];
        bit  ok;
        logic [13:0] sum_at_done[$];

        tbl[0] = 12'd5; tbl[1] = 12'd0; tbl[2] = 12'd7; tbl[3] = 12'd4;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vld", 32'(bus.out_vld), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);

        // Basic frame with ideal receiver; cycle budget and vld duty
        base = cap_n;
        run_frame(1'b1, bcyc, vcyc, dcnt);
        check("f1_done_seen", 32'(dcnt), 32'd1);
        check("f1_busy_cycles", 32'(bcyc), 32'd21);
        check("f1_vld_cycles", 32'(vcyc), 32'd8);
        check("f1_last_data", 32'(bus.out_data), 32'd4);
        check_frame("f1", base);
        check("f1_data_retained", 32'(bus.out_data), 32'd4);
        check("f1_sum_retained", 32'(sum), 32'd16);

        // Receiver holds off capture for 20 cycles on entry 0
        stall = 1'b1;
        base  = cap_n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_vld) begin found = 1; break; end
            @(negedge clk);
        end
        check("stall_vld_seen", 32'(found), 32'd1);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(bus.out_vld && bus.out_data == 12'd5 && addr == 2'd0)) ok = 1'b0;
        end
        check("stall_hold", 32'(ok), 32'd1);
        stall = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin found = 1; break; end
        end
        check("stall_done_seen", 32'(found), 32'd1);
        check_frame("stall", base);

        // Reset while sending entry 2, then a clean resend
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (st == 3'd3 && addr == 2'd2) begin found = 1; break; end
            @(negedge clk);
        end
        check("rst_mid_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", 32'(bus.out_vld), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_sum", 32'(sum), 32'd0);
        check("rst_mid_addr", 32'(addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = cap_n;
        run_frame(1'b1, bcyc, vcyc, dcnt);
        check("resend_done_seen", 32'(dcnt), 32'd1);
        check_frame("resend", base);

        // Narrow counts, all 15; a second start mid-frame must be ignored
        base2 = cap2_n;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (5) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done2) begin found = 1; break; end
        end
        check("w4_done_seen", 32'(found), 32'd1);
        check("w4_sum", 32'(sum2), 32'd60);
        repeat (5) @(negedge clk);
        check("w4_xfers", 32'(cap2_n - base2), 32'd4);
        check("w4_busy_after", 32'(busy2), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [5:0] ci;
            ci = 6'(base2 + k);
            if (cap2[ci] != 4'd15) ok = 1'b0;
        end
        check("w4_values", 32'(ok), 32'd1);

        // start held high for 50 cycles: back-to-back frames with one IDLE gap
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(i);
                sum_at_done.push_back(sum);
            end
            if (i == 23) check("held_sum_cleared", 32'(sum), 32'd0);
        end
        start = 1'b0;
        check("held_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            check("held_first_done", 32'(done_at[0]), 32'd21);
            check("held_done_gap", 32'(done_at[1] - done_at[0]), 32'd23);
            check("held_sum1", 32'(sum_at_done[0]), 32'd16);
            check("held_sum2", 32'(sum_at_done[1]), 32'd16);
        end
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin found = 1; break; end
        end
        check("held_drain", 32'(found), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
